// File: rtl/hamming_scrubber.sv
// Hamming SECDED memory scrubber.
// Walks addresses 0..DEPTH-1 once per start_i pulse. Each word is read and
// decoded. Single-bit errors are corrected and written back. Double errors
// are only counted. A programmable idle gap precedes every read.
// Codeword layout: bit 0 holds overall parity. Positions 1..CW-1 form a
// classic Hamming code with check bits at the power-of-two positions.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i, interval_i pass trigger, idle cycles before each read
//   mem_req_o/we_o/addr_o/wdata_o, mem_gnt_i   request channel
//   mem_rvalid_i, mem_rdata_i                   read-return channel
//   busy_o, done_o                              pass status
//   corr_cnt_o, uncorr_cnt_o, last_err_addr_o   scrub statistics

package gray_area_package;
    // Smallest r with 2**r >= data_width + r + 1.
    function automatic int unsigned hamming_address_width(input int unsigned data_width);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < (data_width + r + 1)) r = r + 1;
        return r;
    endfunction
endpackage

// Combinational SECDED decoder: num_errors_o is 0, 1 (correctable at
// fault_location_o) or 2 (uncorrectable).
module hamming_decode #(
    parameter int unsigned  DATA_WIDTH = 32,
    localparam int unsigned HW = gray_area_package::hamming_address_width(DATA_WIDTH),
    localparam int unsigned CW = DATA_WIDTH + HW + 1
) (
    input  logic [CW-1:0] codeword_i,
    output logic [1:0]    num_errors_o,
    output logic [HW-1:0] fault_location_o
);
    logic [HW-1:0] syndrome;
    logic          parity;

    always_comb begin
        syndrome = '0;
        for (int i = 1; i < int'(CW); i++) begin
            if (codeword_i[i]) syndrome = syndrome ^ HW'(i);
        end
        parity           = ^codeword_i;
        fault_location_o = syndrome;
        if (!parity) begin
            num_errors_o = (syndrome == '0) ? 2'd0 : 2'd2;
        end else if (syndrome > HW'(CW - 1)) begin
            // Odd parity but syndrome points outside the word: not a single flip.
            num_errors_o = 2'd2;
        end else begin
            num_errors_o = 2'd1;
        end
    end
endmodule

module hamming_scrubber #(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  DEPTH      = 256,
    parameter int unsigned  INTERVAL_W = 16,
    localparam int unsigned HW = gray_area_package::hamming_address_width(DATA_WIDTH),
    localparam int unsigned CW = DATA_WIDTH + HW + 1,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [INTERVAL_W-1:0] interval_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [AW-1:0]         mem_addr_o,
    output logic [CW-1:0]         mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [CW-1:0]         mem_rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           corr_cnt_o,
    output logic [15:0]           uncorr_cnt_o,
    output logic [AW-1:0]         last_err_addr_o
);
    typedef enum logic [2:0] {IDLE, GAP, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT} state_t;

    state_t                state_q, state_d;
    logic [INTERVAL_W-1:0] gap_q, interval_q;
    logic [CW-1:0]         rdata_q;
    logic [1:0]            num_errors;
    logic [HW-1:0]         fault_loc;

    logic start_pass, gap_dec, capture, log_corr, log_uncorr, advance, pass_end;

    hamming_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
        .codeword_i       (rdata_q),
        .num_errors_o     (num_errors),
        .fault_location_o (fault_loc)
    );

    // Next-state and per-cycle action decode.
    always_comb begin
        state_d    = state_q;
        start_pass = 1'b0;
        gap_dec    = 1'b0;
        capture    = 1'b0;
        log_corr   = 1'b0;
        log_uncorr = 1'b0;
        advance    = 1'b0;
        pass_end   = 1'b0;
        case (state_q)
            IDLE: begin
                // done_o high means the previous pass ends this cycle; drop start.
                if (start_i && !done_o) begin
                    start_pass = 1'b1;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = RD_REQ;
                else             gap_dec = 1'b1;
            end
            RD_REQ: begin
                if (mem_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                case (num_errors)
                    2'd1: begin
                        log_corr = 1'b1;
                        state_d  = WR_REQ;
                    end
                    2'd2: begin
                        log_uncorr = 1'b1;
                        state_d    = NEXT;
                    end
                    default: state_d = NEXT;
                endcase
            end
            WR_REQ: begin
                if (mem_gnt_i) state_d = NEXT;
            end
            NEXT: begin
                if (mem_addr_o == AW'(DEPTH - 1)) begin
                    pass_end = 1'b1;
                    state_d  = IDLE;
                end else begin
                    advance = 1'b1;
                    state_d = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request outputs and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            gap_q           <= '0;
            interval_q      <= '0;
            rdata_q         <= '0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            corr_cnt_o      <= '0;
            uncorr_cnt_o    <= '0;
            last_err_addr_o <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_o <= (state_d == RD_REQ) || (state_d == WR_REQ);
            mem_we_o  <= (state_d == WR_REQ);
            busy_o    <= (state_d != IDLE);
            done_o    <= pass_end;

            if (start_pass) begin
                mem_addr_o   <= '0;
                gap_q        <= interval_i;
                interval_q   <= interval_i;
                corr_cnt_o   <= '0;
                uncorr_cnt_o <= '0;
            end else if (advance) begin
                mem_addr_o <= mem_addr_o + AW'(1);
                gap_q      <= interval_q;
            end else if (gap_dec) begin
                gap_q <= gap_q - INTERVAL_W'(1);
            end

            if (capture) rdata_q <= mem_rdata_i;

            if (log_corr) begin
                if (corr_cnt_o != 16'hFFFF) corr_cnt_o <= corr_cnt_o + 16'd1;
                last_err_addr_o <= mem_addr_o;
                mem_wdata_o     <= rdata_q ^ (CW'(1) << fault_loc);
            end

            if (log_uncorr) begin
                if (uncorr_cnt_o != 16'hFFFF) uncorr_cnt_o <= uncorr_cnt_o + 16'd1;
                last_err_addr_o <= mem_addr_o;
            end
        end
    end
endmodule

// File: tb/tb_hamming_scrubber.sv
// Self-checking bench for hamming_scrubber (DEPTH=4, 32-bit payload).
// A memory model answers requests; expectations come from the known
// original codewords and the number of bits flipped in each word.
module tb_hamming_scrubber;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 16;
    localparam int unsigned HW    = 6;
    localparam int unsigned CW    = DW + HW + 1;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [IW-1:0] interval_i = '0;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [CW-1:0] mem_wdata_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [CW-1:0] mem_rdata_i = '0;
    logic          busy_o, done_o;
    logic [15:0]   corr_cnt_o, uncorr_cnt_o;
    logic [AW-1:0] last_err_addr_o;

    hamming_scrubber #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INTERVAL_W(IW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .interval_i(interval_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o),
        .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o),
        .last_err_addr_o(last_err_addr_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents and per-word injected error count.
    logic [CW-1:0] mem_orig [DEPTH];
    logic [CW-1:0] mem_arr  [DEPTH];
    int            nerr     [DEPTH];

    // Responder knobs and logs.
    int            gnt_prob = 100;
    int            lat_min = 1, lat_max = 1;
    bit            gnt_en = 1'b1;
    int            stall_left = 0;
    int            rd_log[$];
    int            wr_addr_log[$];
    logic [CW-1:0] wr_data_log[$];
    int            req_rise_q[$];
    int            rv_q[$];
    int            done_cnt = 0;
    bit            rd_pending = 1'b0;
    int            rd_delay = 0;
    logic [CW-1:0] rd_data = '0;
    bit            prev_req = 1'b0;

    // Expected results.
    int            exp_wr_addr[$];
    logic [CW-1:0] exp_wr_data[$];
    int            exp_corr, exp_uncorr;
    int            exp_last = 0;

    // Memory model: decides grant for the coming edge, returns read data later.
    always @(negedge clk) begin
        mem_rvalid_i = 1'b0;
        if (rd_pending) begin
            if (rd_delay == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rd_data;
                rd_pending   = 1'b0;
                rv_q.push_back(cyc);
            end else begin
                rd_delay--;
            end
        end
        if (done_o) done_cnt++;
        if (mem_req_o && !mem_we_o && !prev_req) req_rise_q.push_back(cyc);
        prev_req  = mem_req_o;
        mem_gnt_i = 1'b0;
        if (mem_req_o && !rst) begin
            if (stall_left > 0) begin
                stall_left--;
            end else if (gnt_en && int'($urandom_range(99)) < gnt_prob) begin
                mem_gnt_i = 1'b1;
                if (mem_we_o) begin
                    wr_addr_log.push_back(int'(mem_addr_o));
                    wr_data_log.push_back(mem_wdata_o);
                    mem_arr[mem_addr_o] = mem_wdata_o;
                end else begin
                    rd_log.push_back(int'(mem_addr_o));
                    rd_pending = 1'b1;
                    rd_delay   = int'($urandom_range(lat_max, lat_min)) - 1;
                    rd_data    = mem_arr[mem_addr_o];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // SECDED encoder: data in non-power-of-two positions, check bits make
    // every syndrome group even, bit 0 makes the whole word even.
    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int            j;
        logic          x;
        c = '0;
        j = 0;
        for (int pos = 1; pos < int'(CW); pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                j++;
            end
        end
        for (int p = 0; p < int'(HW); p++) begin
            x = 1'b0;
            for (int pos = 1; pos < int'(CW); pos++)
                if (((pos >> p) & 1) != 0) x ^= c[pos];
            c[1 << p] = x;
        end
        c[0] = ^c;
        return c;
    endfunction

    task automatic load_clean();
        for (int a = 0; a < int'(DEPTH); a++) begin
            mem_orig[a] = encode($urandom);
            mem_arr[a]  = mem_orig[a];
            nerr[a]     = 0;
        end
    endtask

    task automatic flip(input int a, input int b);
        mem_arr[a][b] = ~mem_arr[a][b];
        nerr[a]++;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        req_rise_q.delete();
        rv_q.delete();
        done_cnt = 0;
    endtask

    task automatic build_expect();
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_corr   = 0;
        exp_uncorr = 0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            if (nerr[a] == 1) begin
                exp_wr_addr.push_back(a);
                exp_wr_data.push_back(mem_orig[a]);
                exp_corr++;
                exp_last = a;
            end else if (nerr[a] == 2) begin
                exp_uncorr++;
                exp_last = a;
            end
        end
    endtask

    task automatic run_pass(input int interval, output int sc, output bit timed_out);
        clear_logs();
        interval_i = IW'(interval);
        start_i    = 1'b1;
        sc         = cyc;
        tick();
        start_i   = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (done_o) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({mem_req_o, mem_we_o, busy_o, done_o} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_req_o, mem_we_o, busy_o, done_o});
        end
        n_cmp++;
        if ({mem_addr_o, mem_wdata_o} !== '0) begin
            n_fail++; $display("FAIL reset_data: got addr %0d wdata %h expected 0", mem_addr_o, mem_wdata_o);
        end
        n_cmp++;
        if ({corr_cnt_o, uncorr_cnt_o, last_err_addr_o} !== '0) begin
            n_fail++; $display("FAIL reset_stats: got %0d/%0d/%0d expected 0", corr_cnt_o, uncorr_cnt_o, last_err_addr_o);
        end
        rst = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got busy %b req %b expected 0 0", busy_o, mem_req_o);
        end
    endtask

    task automatic test_clean();
        int sc; bit to;
        load_clean();
        gnt_prob = 100; lat_min = 1; lat_max = 1;
        run_pass(0, sc, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL clean_timeout: no done_o within budget"); end
        n_cmp++;
        if (rd_log.size() != int'(DEPTH)) begin
            n_fail++; $display("FAIL clean_reads: got %0d expected %0d", rd_log.size(), DEPTH);
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                n_cmp++;
                if (rd_log[i] != i) begin n_fail++; $display("FAIL clean_rd_addr: got %0d expected %0d", rd_log[i], i); end
            end
        end
        n_cmp++;
        if (wr_addr_log.size() != 0) begin n_fail++; $display("FAIL clean_writes: got %0d expected 0", wr_addr_log.size()); end
        n_cmp++;
        if (corr_cnt_o !== 16'd0 || uncorr_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL clean_counts: got %0d/%0d expected 0/0", corr_cnt_o, uncorr_cnt_o);
        end
        n_cmp++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL clean_done: got %0d pulses expected 1", done_cnt); end
    endtask

    task automatic test_single();
        int sc; bit to;
        load_clean();
        flip(2, 5);
        run_pass(0, sc, to);
        exp_last = 2;
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL single_timeout: no done_o within budget"); end
        n_cmp++;
        if (wr_addr_log.size() != 1) begin
            n_fail++; $display("FAIL single_writes: got %0d expected 1", wr_addr_log.size());
        end else begin
            n_cmp++;
            if (wr_addr_log[0] != 2) begin n_fail++; $display("FAIL single_wr_addr: got %0d expected 2", wr_addr_log[0]); end
            n_cmp++;
            if (wr_data_log[0] !== mem_orig[2]) begin
                n_fail++; $display("FAIL single_wr_data: got %h expected %h", wr_data_log[0], mem_orig[2]);
            end
        end
        n_cmp++;
        if (corr_cnt_o !== 16'd1 || uncorr_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL single_counts: got %0d/%0d expected 1/0", corr_cnt_o, uncorr_cnt_o);
        end
        n_cmp++;
        if (last_err_addr_o !== AW'(2)) begin n_fail++; $display("FAIL single_last: got %0d expected 2", last_err_addr_o); end
    endtask

    task automatic test_double();
        int sc; bit to;
        load_clean();
        flip(1, 3);
        flip(1, 9);
        run_pass(0, sc, to);
        exp_last = 1;
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL double_timeout: no done_o within budget"); end
        n_cmp++;
        if (wr_addr_log.size() != 0) begin n_fail++; $display("FAIL double_writes: got %0d expected 0", wr_addr_log.size()); end
        n_cmp++;
        if (corr_cnt_o !== 16'd0 || uncorr_cnt_o !== 16'd1) begin
            n_fail++; $display("FAIL double_counts: got %0d/%0d expected 0/1", corr_cnt_o, uncorr_cnt_o);
        end
        n_cmp++;
        if (last_err_addr_o !== AW'(1)) begin n_fail++; $display("FAIL double_last: got %0d expected 1", last_err_addr_o); end
        n_cmp++;
        if (rd_log.size() != int'(DEPTH)) begin n_fail++; $display("FAIL double_reads: got %0d expected %0d", rd_log.size(), DEPTH); end
    endtask

    task automatic test_stall();
        bit seen, fin;
        int zeros;
        load_clean();
        clear_logs();
        stall_left = 10;
        interval_i = '0;
        start_i    = 1'b1;
        tick();
        start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (mem_req_o) begin seen = 1'b1; break; end
            tick();
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL stall_req_seen: got no request expected one"); end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== '0) begin
                n_fail++; $display("FAIL stall_hold: cycle %0d got req %b we %b addr %0d expected 1 0 0", k, mem_req_o, mem_we_o, mem_addr_o);
            end
            tick();
        end
        fin = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (done_o) begin fin = 1'b1; break; end
            tick();
        end
        repeat (2) tick();
        n_cmp++;
        if (!fin) begin n_fail++; $display("FAIL stall_timeout: no done_o within budget"); end
        zeros = 0;
        foreach (rd_log[i]) if (rd_log[i] == 0) zeros++;
        n_cmp++;
        if (zeros != 1 || rd_log.size() != int'(DEPTH)) begin
            n_fail++; $display("FAIL stall_reads: got %0d reads of addr0, %0d total expected 1, %0d", zeros, rd_log.size(), DEPTH);
        end
    endtask

    task automatic test_interval();
        int sc; bit to;
        load_clean();
        lat_min = 1; lat_max = 3;
        run_pass(5, sc, to);
        n_cmp++;
        if (to || req_rise_q.size() != int'(DEPTH) || rv_q.size() != int'(DEPTH)) begin
            n_fail++; $display("FAIL interval_count: got %0d req %0d rvalid to=%b expected %0d", req_rise_q.size(), rv_q.size(), to, DEPTH);
        end else begin
            n_cmp++;
            if (req_rise_q[0] != sc + 2 + 5) begin
                n_fail++; $display("FAIL interval_first: got cycle %0d expected %0d", req_rise_q[0], sc + 7);
            end
            for (int k = 1; k < int'(DEPTH); k++) begin
                n_cmp++;
                if (req_rise_q[k] != rv_q[k-1] + 4 + 5) begin
                    n_fail++; $display("FAIL interval_gap: word %0d got cycle %0d expected %0d", k, req_rise_q[k], rv_q[k-1] + 9);
                end
            end
        end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_start_ignored();
        bit fin;
        load_clean();
        clear_logs();
        interval_i = IW'(2);
        start_i    = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        start_i    = 1'b1;
        interval_i = '0;
        tick();
        start_i = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (done_o) begin fin = 1'b1; break; end
            tick();
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_cmp++;
        if (!fin) begin n_fail++; $display("FAIL ign_timeout: no done_o within budget"); end
        n_cmp++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ign_done_start: got busy %b expected 0", busy_o); end
        repeat (4) tick();
        n_cmp++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL ign_idle: got busy %b req %b expected 0 0", busy_o, mem_req_o);
        end
        n_cmp++;
        if (rd_log.size() != int'(DEPTH) || done_cnt != 1) begin
            n_fail++; $display("FAIL ign_busy_start: got %0d reads %0d done expected %0d 1", rd_log.size(), done_cnt, DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int sc; bit to;
        load_clean();
        flip(0, 12);
        clear_logs();
        interval_i = '0;
        start_i    = 1'b1;
        tick();
        start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (mem_req_o && mem_we_o) begin seen = 1'b1; break; end
            tick();
        end
        gnt_en = 1'b0;
        rst    = 1'b1;
        tick();
        exp_last = 0;
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL rstwr_seen: got no write request expected one"); end
        n_cmp++;
        if ({mem_req_o, mem_we_o, busy_o, done_o} !== 4'b0) begin
            n_fail++; $display("FAIL rstwr_ctrl: got %b expected 0000", {mem_req_o, mem_we_o, busy_o, done_o});
        end
        n_cmp++;
        if ({corr_cnt_o, uncorr_cnt_o, last_err_addr_o, mem_addr_o, mem_wdata_o} !== '0) begin
            n_fail++; $display("FAIL rstwr_regs: got %0d/%0d/%0d addr %0d wdata %h expected 0", corr_cnt_o, uncorr_cnt_o, last_err_addr_o, mem_addr_o, mem_wdata_o);
        end
        rst    = 1'b0;
        gnt_en = 1'b1;
        tick();
        // Reset while a read is outstanding; its late rvalid must not restart anything.
        clear_logs();
        lat_min = 4; lat_max = 4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (rd_log.size() > 0) break;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || rv_q.size() != 1) begin
            n_fail++; $display("FAIL rstrd_stale: got busy %b req %b rvalids %0d expected 0 0 1", busy_o, mem_req_o, rv_q.size());
        end
        lat_min = 1; lat_max = 1;
        run_pass(0, sc, to);
        exp_last = 0;
        n_cmp++;
        if (to || rd_log.size() != int'(DEPTH) || rd_log[0] != 0) begin
            n_fail++; $display("FAIL rst_restart_reads: got %0d reads to=%b expected %0d from addr 0", rd_log.size(), to, DEPTH);
        end
        n_cmp++;
        if (corr_cnt_o !== 16'd1 || wr_addr_log.size() != 1) begin
            n_fail++; $display("FAIL rst_restart_corr: got corr %0d writes %0d expected 1 1", corr_cnt_o, wr_addr_log.size());
        end else begin
            n_cmp++;
            if (wr_addr_log[0] != 0 || wr_data_log[0] !== mem_orig[0]) begin
                n_fail++; $display("FAIL rst_restart_wr: got addr %0d data %h expected 0 %h", wr_addr_log[0], wr_data_log[0], mem_orig[0]);
            end
        end
    endtask

    task automatic test_random();
        int sc; bit to;
        int n, b1, b2;
        for (int it = 0; it < 8; it++) begin
            load_clean();
            for (int a = 0; a < int'(DEPTH); a++) begin
                n  = int'($urandom_range(2));
                b1 = int'($urandom_range(CW - 1));
                if (n >= 1) flip(a, b1);
                if (n == 2) begin
                    do b2 = int'($urandom_range(CW - 1)); while (b2 == b1);
                    flip(a, b2);
                end
            end
            gnt_prob = int'($urandom_range(100, 30));
            lat_min  = 1;
            lat_max  = int'($urandom_range(4, 1));
            build_expect();
            run_pass(int'($urandom_range(3)), sc, to);
            n_cmp++;
            if (to) begin n_fail++; $display("FAIL rand_timeout: pass %0d no done_o", it); end
            n_cmp++;
            if (rd_log.size() != int'(DEPTH)) begin
                n_fail++; $display("FAIL rand_reads: pass %0d got %0d expected %0d", it, rd_log.size(), DEPTH);
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    n_cmp++;
                    if (rd_log[i] != i) begin n_fail++; $display("FAIL rand_rd_addr: pass %0d got %0d expected %0d", it, rd_log[i], i); end
                end
            end
            n_cmp++;
            if (wr_addr_log.size() != exp_wr_addr.size()) begin
                n_fail++; $display("FAIL rand_writes: pass %0d got %0d expected %0d", it, wr_addr_log.size(), exp_wr_addr.size());
            end else begin
                foreach (exp_wr_addr[i]) begin
                    n_cmp++;
                    if (wr_addr_log[i] != exp_wr_addr[i] || wr_data_log[i] !== exp_wr_data[i]) begin
                        n_fail++; $display("FAIL rand_wr: pass %0d got %0d:%h expected %0d:%h", it, wr_addr_log[i], wr_data_log[i], exp_wr_addr[i], exp_wr_data[i]);
                    end
                end
            end
            n_cmp++;
            if (corr_cnt_o !== 16'(exp_corr) || uncorr_cnt_o !== 16'(exp_uncorr)) begin
                n_fail++; $display("FAIL rand_counts: pass %0d got %0d/%0d expected %0d/%0d", it, corr_cnt_o, uncorr_cnt_o, exp_corr, exp_uncorr);
            end
            n_cmp++;
            if (last_err_addr_o !== AW'(exp_last)) begin
                n_fail++; $display("FAIL rand_last: pass %0d got %0d expected %0d", it, last_err_addr_o, exp_last);
            end
            n_cmp++;
            if (done_cnt != 1) begin n_fail++; $display("FAIL rand_done: pass %0d got %0d pulses expected 1", it, done_cnt); end
            for (int a = 0; a < int'(DEPTH); a++) begin
                if (nerr[a] < 2) begin
                    n_cmp++;
                    if (mem_arr[a] !== mem_orig[a]) begin
                        n_fail++; $display("FAIL rand_mem: pass %0d addr %0d got %h expected %h", it, a, mem_arr[a], mem_orig[a]);
                    end
                end
            end
        end
        gnt_prob = 100; lat_min = 1; lat_max = 1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_stall();
        test_interval();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hamming_scrubber.md
HAMMING_SCRUBBER -- requirements
Module: hamming_scrubber

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload bits per memory word; CW = DATA_WIDTH + hamming_address_width(DATA_WIDTH) + 1 (39 at default), HW = hamming_address_width(DATA_WIDTH), both taken from gray_area_package.
REQ-002 Parameter DEPTH, default 256: words to scrub, addresses 0..DEPTH-1; AW = $clog2(DEPTH).
REQ-003 Parameter INTERVAL_W, default 16: width of inter-word gap counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  one-cycle pulse, begins one full pass; ignored while busy_o=1.
REQ-007 interval_i  in  INTERVAL_W  idle cycles inserted before each word read; sampled at start_i.
REQ-008 mem_req_o  out  1  memory access request, held until granted.
REQ-009 mem_we_o  out  1  1=write-back, 0=read; valid while mem_req_o=1.
REQ-010 mem_addr_o  out  AW  word address; valid while mem_req_o=1.
REQ-011 mem_wdata_o  out  CW  corrected codeword for write-back.
REQ-012 mem_gnt_i  in  1  request accepted this cycle when mem_req_o=1.
REQ-013 mem_rvalid_i  in  1  read data valid; arrives >=1 cycle after read grant, exactly once per granted read.
REQ-014 mem_rdata_i  in  CW  read codeword.
REQ-015 busy_o  out  1  pass in progress.
REQ-016 done_o  out  1  one-cycle pulse at end of pass.
REQ-017 corr_cnt_o  out  16  single-bit errors corrected, saturating at 16'hFFFF.
REQ-018 uncorr_cnt_o  out  16  double errors detected, saturating.
REQ-019 last_err_addr_o  out  AW  address of most recent error of either kind.

Function
REQ-020 Block SHALL instantiate hamming_decode on the captured read word and use its num_errors_o and fault_location_o.
REQ-021 FSM states SHALL be IDLE, GAP, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
REQ-022 IDLE->GAP on start_i; address register cleared to 0, gap counter loaded with interval_i, counters cleared, busy_o=1 from following cycle.
REQ-023 GAP: counter decrements per cycle; exits to RD_REQ in the cycle it equals 0 (interval_i=0 -> zero extra cycles).
REQ-024 RD_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=address; stays until mem_gnt_i=1, then RD_WAIT; req/addr SHALL not change while ungranted.
REQ-025 RD_WAIT: on mem_rvalid_i=1 capture mem_rdata_i into register, go CHECK; rvalid outside RD_WAIT SHALL be ignored.
REQ-026 CHECK (one cycle): num_errors 0 -> NEXT; 2 -> uncorr_cnt_o+1, last_err_addr_o=address, NEXT; 1 -> corr_cnt_o+1, last_err_addr_o=address, mem_wdata_o = captured word with bit fault_location inverted, WR_REQ.
REQ-027 WR_REQ: mem_req_o=1, mem_we_o=1, same address, held until mem_gnt_i=1, then NEXT.
REQ-028 NEXT: if address==DEPTH-1 -> IDLE with done_o=1 that cycle-transition (asserted the cycle busy_o falls); else address+1, reload gap counter, GAP.
REQ-029 Counters SHALL saturate, never wrap; they hold their value after the pass until next start_i.
REQ-030 Words with 2 errors SHALL NOT be written back.
REQ-031 mem_req_o SHALL be 0 in IDLE, GAP, RD_WAIT, CHECK, NEXT.
REQ-032 start_i coincident with done_o SHALL be ignored (block not yet IDLE).

Reset
REQ-033 rst=1 at any time, including mid-access, SHALL force IDLE next edge: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, counters=0, last_err_addr_o=0; an outstanding rvalid after reset SHALL be ignored.

Verification
REQ-034 DEPTH=4, clean memory, interval_i=0, gnt always 1, rvalid 1 cycle after grant -> 4 reads, no writes, corr=0, uncorr=0, one done_o pulse.
REQ-035 Word 2 with bit 5 flipped -> one write at addr 2, mem_wdata_o equals original codeword, corr_cnt_o=1, last_err_addr_o=2.
REQ-036 Word 1 with bits 3 and 9 flipped -> no write, uncorr_cnt_o=1, last_err_addr_o=1.
REQ-037 mem_gnt_i held low 10 cycles during RD_REQ -> mem_req_o and mem_addr_o stable all 10 cycles, single read issued.
REQ-038 interval_i=5 -> exactly 5 cycles between NEXT/start and each read request.
REQ-039 rst pulsed during WR_REQ -> next cycle mem_req_o=0, busy_o=0, counters 0; new start_i restarts from address 0.
